// File: rtl/popcount_seq_ctrl.sv
// popcount_seq_ctrl: sequential population counter for a 255-bit vector.
// The vector is captured into a 256-bit shadow register, with bit 255 held at
// zero. Then CHUNK_W bits are counted on each clock into an 8-bit accumulator.
// The result is returned through a valid/ready handshake.
// Optional feature macro: POPCOUNT_THRESH_EN. It adds the thresh input and the
// out_ge flag, which is a registered compare of the result against a
// threshold captured when the vector is accepted.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// BUSY  | counting one chunk per cycle, busy=1
// DONE  | result held on out_count, out_valid=1 until out_ready
module popcount_seq_ctrl #(
  parameter int CHUNK_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [254:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_count,
  output logic         busy
`ifdef POPCOUNT_THRESH_EN
  ,
  input  logic [7:0]   thresh,
  output logic         out_ge
`endif
);

  localparam int NCHUNK = 256 / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [255:0]     shadow;
  logic [7:0]       acc;
  logic [IDX_W-1:0] idx;
  logic [CHUNK_W-1:0] chunk;
  logic [8:0]       chunk_ones;
  logic [7:0]       acc_next;
`ifdef POPCOUNT_THRESH_EN
  logic [7:0]       thresh_q;
`endif

  // Count the ones in the chunk that idx selects. The accumulator cannot wrap
  // because bit 255 of the shadow register is always zero.
  always_comb begin
    chunk      = CHUNK_W'(shadow >> (int'(idx) * CHUNK_W));
    chunk_ones = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      chunk_ones = chunk_ones + 9'(chunk[i]);
    end
    acc_next = acc + chunk_ones[7:0];
  end

  assign out_count = acc;

  // Control FSM. All handshake and status outputs are registered with the
  // state. clear has priority over every other input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      acc       <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
`ifdef POPCOUNT_THRESH_EN
      thresh_q  <= '0;
      out_ge    <= 1'b0;
`endif
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
`ifdef POPCOUNT_THRESH_EN
      out_ge    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shadow   <= {1'b0, in_data};
            acc      <= '0;
            idx      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef POPCOUNT_THRESH_EN
            thresh_q <= thresh;
`endif
          end
        end
        BUSY: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
`ifdef POPCOUNT_THRESH_EN
            out_ge    <= (acc_next >= thresh_q);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Testbench for popcount_seq_ctrl.
// dut0 uses the default CHUNK_W=16 and dut1 uses CHUNK_W=1; the two share all inputs.
module tb_popcount_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [254:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [7:0]   out_count;
  logic         in_ready1, out_valid1, busy1;
  logic [7:0]   out_count1;
`ifdef POPCOUNT_THRESH_EN
  logic [7:0]   thresh = '0;
  logic         out_ge, out_ge1;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  popcount_seq_ctrl #(.CHUNK_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .busy(busy)
`ifdef POPCOUNT_THRESH_EN
    , .thresh(thresh), .out_ge(out_ge)
`endif
  );

  popcount_seq_ctrl #(.CHUNK_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready1), .in_data(in_data), .out_valid(out_valid1),
    .out_ready(out_ready), .out_count(out_count1), .busy(busy1)
`ifdef POPCOUNT_THRESH_EN
    , .thresh(thresh), .out_ge(out_ge1)
`endif
  );

  // Reference model: the result is the number of ones in the accepted vector.
  function automatic logic [7:0] ref_count(input logic [254:0] d);
    return 8'($countones(d));
  endfunction

  function automatic logic [254:0] rand_vec();
    logic [255:0] t;
    logic [255:0] m;
    for (int i = 0; i < 8; i++) begin
      t[i*32 +: 32] = $urandom;
      m[i*32 +: 32] = $urandom;
    end
    case ($urandom_range(0, 2))
      0: t = t & m;
      1: t = t | m;
      default: ;
    endcase
    return t[254:0];
  endfunction

  // Present one vector for one cycle, then wait for out_valid on dut0.
  // lat is the number of clock edges between the accepting edge and out_valid,
  // or -1 if out_valid does not arrive within the limit.
  // When noise is set, in_data and in_valid are scrambled while the block is busy.
  task automatic start_and_wait(input logic [254:0] d, input bit noise,
                                input int limit, output int lat);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < limit) begin
      if (noise) begin
        in_data  = rand_vec();
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) lat = -1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL reset_flags got %b want 100", {in_ready, busy, out_valid}); else pass_cnt++;
    total++; if (out_count !== 8'd0) $display("FAIL reset_count got %0d want 0", out_count); else pass_cnt++;
    total++; if (in_ready1 !== 1'b1) $display("FAIL reset_ready_w1 got %b want 1", in_ready1); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ones_both_widths();
    int c, lat0;
    @(negedge clk);
    in_data  = '1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0; lat0 = -1;
    while (!out_valid1 && c < 400) begin
      if (out_valid && lat0 < 0) lat0 = c;
      @(negedge clk);
      c++;
    end
    total++; if (lat0 !== 16) $display("FAIL ones_lat16 got %0d want 16", lat0); else pass_cnt++;
    total++; if (c !== 256) $display("FAIL ones_lat1 got %0d want 256", c); else pass_cnt++;
    total++; if (out_count !== 8'hFF) $display("FAIL ones_cnt16 got %0d want 255", out_count); else pass_cnt++;
    total++; if (out_count1 !== 8'hFF) $display("FAIL ones_cnt1 got %0d want 255", out_count1); else pass_cnt++;
    handshake();
    total++; if ({in_ready, in_ready1} !== 2'b11) $display("FAIL ones_release got %b want 11", {in_ready, in_ready1}); else pass_cnt++;
  endtask

  task automatic test_patterns();
    logic [254:0] d [3];
    int lat;
    d[0] = '0;
    d[1] = '0; d[1][254] = 1'b1;
    d[2] = '0;
    for (int i = 0; i < 255; i += 2) d[2][i] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_and_wait(d[k], 1'b0, 100, lat);
      total++; if (lat !== 16) $display("FAIL pattern%0d_lat got %0d want 16", k, lat); else pass_cnt++;
      total++; if (out_count !== ref_count(d[k])) $display("FAIL pattern%0d_cnt got %0d want %0d", k, out_count, ref_count(d[k])); else pass_cnt++;
      handshake();
    end
  endtask

  task automatic test_random();
    logic [254:0] d;
    int lat;
    for (int k = 0; k < 12; k++) begin
      d = rand_vec();
`ifdef POPCOUNT_THRESH_EN
      thresh = 8'($urandom_range(0, 255));
`endif
      start_and_wait(d, 1'b1, 100, lat);
      total++; if (lat !== 16) $display("FAIL rand%0d_lat got %0d want 16", k, lat); else pass_cnt++;
      total++; if (out_count !== ref_count(d)) $display("FAIL rand%0d_cnt got %0d want %0d", k, out_count, ref_count(d)); else pass_cnt++;
`ifdef POPCOUNT_THRESH_EN
      total++; if (out_ge !== (ref_count(d) >= thresh)) $display("FAIL rand%0d_ge got %b want %b", k, out_ge, ref_count(d) >= thresh); else pass_cnt++;
`endif
      handshake();
    end
  endtask

  task automatic test_stall();
    logic [254:0] d;
    int lat;
    d = rand_vec();
    start_and_wait(d, 1'b0, 100, lat);
    total++; if (lat !== 16) $display("FAIL stall_lat got %0d want 16", lat); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      in_data  = rand_vec();
      in_valid = 1'b1;
      @(negedge clk);
      total++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL stall%0d_flags got %b want 10", k, {out_valid, in_ready}); else pass_cnt++;
      total++; if (out_count !== ref_count(d)) $display("FAIL stall%0d_cnt got %0d want %0d", k, out_count, ref_count(d)); else pass_cnt++;
    end
    in_valid = 1'b0;
    handshake();
    total++; if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL stall_release got %b want 010", {out_valid, in_ready, busy}); else pass_cnt++;
  endtask

  task automatic test_clear();
    logic [254:0] d;
    int lat, seen;
    @(negedge clk);
    in_data  = rand_vec();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    total++; if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL clear_flags got %b want 100", {in_ready, busy, out_valid}); else pass_cnt++;
    total++; if (out_count !== 8'd0) $display("FAIL clear_acc got %0d want 0", out_count); else pass_cnt++;
    seen = 0;
    repeat (30) begin @(negedge clk); if (out_valid) seen++; end
    total++; if (seen !== 0) $display("FAIL clear_no_valid got %0d pulses want 0", seen); else pass_cnt++;
    d = rand_vec();
    start_and_wait(d, 1'b0, 100, lat);
    total++; if (lat !== 16 || out_count !== ref_count(d)) $display("FAIL clear_next got lat %0d cnt %0d want lat 16 cnt %0d", lat, out_count, ref_count(d)); else pass_cnt++;
    handshake();
  endtask

  task automatic test_reset_mid();
    logic [254:0] d;
    int lat, seen;
    @(negedge clk);
    in_data  = rand_vec();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL rstmid_flags got %b want 100", {in_ready, busy, out_valid}); else pass_cnt++;
    total++; if (out_count !== 8'd0) $display("FAIL rstmid_acc got %0d want 0", out_count); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin @(negedge clk); if (out_valid) seen++; end
    total++; if (seen !== 0) $display("FAIL rstmid_no_valid got %0d pulses want 0", seen); else pass_cnt++;
    d = rand_vec();
    start_and_wait(d, 1'b0, 100, lat);
    total++; if (lat !== 16 || out_count !== ref_count(d)) $display("FAIL rstmid_next got lat %0d cnt %0d want lat 16 cnt %0d", lat, out_count, ref_count(d)); else pass_cnt++;
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [254:0] d1, d2;
    int lat;
    d1 = rand_vec();
    d2 = ~d1;
    start_and_wait(d1, 1'b0, 100, lat);
    total++; if (out_count !== ref_count(d1)) $display("FAIL b2b_first got %0d want %0d", out_count, ref_count(d1)); else pass_cnt++;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d2;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if ({in_ready, busy} !== 2'b10) $display("FAIL b2b_no_accept got %b want 10", {in_ready, busy}); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({in_ready, busy} !== 2'b01) $display("FAIL b2b_accept got %b want 01", {in_ready, busy}); else pass_cnt++;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    total++; if (lat !== 16 || out_count !== ref_count(d2)) $display("FAIL b2b_second got lat %0d cnt %0d want lat 16 cnt %0d", lat, out_count, ref_count(d2)); else pass_cnt++;
    handshake();
  endtask

`ifdef POPCOUNT_THRESH_EN
  task automatic test_thresh();
    logic [254:0] d;
    int lat;
    d = '0;
    for (int i = 0; i < 255; i += 2) d[i] = 1'b1;
    thresh = 8'd128;
    start_and_wait(d, 1'b0, 100, lat);
    total++; if (out_ge !== 1'b1) $display("FAIL thresh128 got %b want 1", out_ge); else pass_cnt++;
    handshake();
    thresh = 8'd129;
    start_and_wait(d, 1'b0, 100, lat);
    total++; if (out_ge !== 1'b0) $display("FAIL thresh129 got %b want 0", out_ge); else pass_cnt++;
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_ones_both_widths();
    test_patterns();
    test_random();
    test_stall();
    test_clear();
    test_reset_mid();
    test_back_to_back();
`ifdef POPCOUNT_THRESH_EN
    test_thresh();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
